// File: rtl/game_tick_pkg.sv
// Shared types and defaults for the game tick scheduler: FSM state encoding,
// default divider constants and the agent index width helper.
package game_tick_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} sched_state_t;

  localparam int unsigned DEF_PIX_DIV     = 4;
  localparam int unsigned DEF_CLKS_PER_MS = 100000;
  localparam int unsigned DEF_STEP_MS     = 16;
  localparam int unsigned DEF_N_AGENTS    = 5;
  localparam int unsigned DEF_TIMEOUT_MS  = 4;

  // A single agent still needs a 1-bit index.
  function automatic int unsigned agent_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned AGENT_IDX_W = agent_idx_w(DEF_N_AGENTS);

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Scheduler <-> game logic bundle: run/done from the agents side, strobes,
// grants and status flags from the scheduler side.
interface game_tick_scheduler_if
  import game_tick_pkg::*;
#(
  parameter int unsigned N_AGENTS = DEF_N_AGENTS
);
  logic                run;
  logic [N_AGENTS-1:0] done;
  logic                pix_en;
  logic                ms_tick;
  logic                step_start;
  logic [N_AGENTS-1:0] grant;
  logic                busy;
  logic                overrun;
  logic [N_AGENTS-1:0] timeout_flags;

  modport master (
    input  run, done,
    output pix_en, ms_tick, step_start, grant, busy, overrun, timeout_flags
  );

  modport slave (
    output run, done,
    input  pix_en, ms_tick, step_start, grant, busy, overrun, timeout_flags
  );
endinterface

// File: rtl/tick_divider.sv
// Free-running divider: counts 0..DIV-1 and emits a registered one-cycle
// strobe in the cycle after the counter reaches DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            wrap;

  assign wrap = (cnt_q == CntW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
      tick  <= wrap;
    end
  end
endmodule

// File: rtl/game_tick_scheduler.sv
// Game timing: pixel and 1 ms strobes plus a periodic step that grants agents
// in fixed order. Define UPD_TIMEOUT_EN to enable per-grant ms timeouts.
module game_tick_scheduler
  import game_tick_pkg::*;
#(
  parameter int unsigned PIX_DIV     = DEF_PIX_DIV,
  parameter int unsigned CLKS_PER_MS = DEF_CLKS_PER_MS,
  parameter int unsigned STEP_MS     = DEF_STEP_MS,
`ifdef UPD_TIMEOUT_EN
  parameter int unsigned TIMEOUT_MS  = DEF_TIMEOUT_MS,
`endif
  parameter int unsigned N_AGENTS    = DEF_N_AGENTS
) (
  input  logic                  clk,
  input  logic                  rst,
  game_tick_scheduler_if.master bus
);
  localparam int unsigned          IdxW    = agent_idx_w(N_AGENTS);
  localparam int unsigned          StepW   = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(N_AGENTS - 1);

  logic                pix_en, ms_tick;
  logic [StepW-1:0]    step_cnt_q, step_cnt_d;
  logic                pend_q, pend_d, overrun_q, overrun_d;
  logic                due, consume, adv;
  sched_state_t        state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [N_AGENTS-1:0] grant_q, grant_d;
  logic                busy_q, busy_d, step_start_q, step_start_d;
  logic [N_AGENTS-1:0] timeout_flags;

  tick_divider #(.DIV(PIX_DIV)) u_pix_div (.clk(clk), .rst(rst), .tick(pix_en));
  tick_divider #(.DIV(CLKS_PER_MS)) u_ms_div (.clk(clk), .rst(rst), .tick(ms_tick));

  assign due     = bus.run && ms_tick && (step_cnt_q == StepW'(STEP_MS - 1));
  assign consume = (state_q == IDLE) && pend_q && bus.run;

  // A due step arriving as IDLE consumes the old one simply re-arms pend.
  always_comb begin
    step_cnt_d = step_cnt_q;
    if (!bus.run) step_cnt_d = '0;
    else if (ms_tick) step_cnt_d = due ? '0 : step_cnt_q + 1'b1;
    pend_d    = due | (pend_q & ~consume);
    overrun_d = overrun_q | (due & pend_q & ~consume);
  end

`ifdef UPD_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [N_AGENTS-1:0] tmo_flags_q, tmo_flags_d;
  logic                tmo_hit;

  assign tmo_hit = (state_q == GRANT) && ms_tick && !bus.done[idx_q] &&
                   (tmo_cnt_q == TmoW'(TIMEOUT_MS - 1));
  assign adv     = (state_q == GRANT) && (bus.done[idx_q] || tmo_hit);

  always_comb begin
    tmo_cnt_d   = tmo_cnt_q;
    tmo_flags_d = tmo_flags_q;
    if (state_q != GRANT || adv) tmo_cnt_d = '0;
    else if (ms_tick) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (tmo_hit) tmo_flags_d[idx_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q   <= '0;
      tmo_flags_q <= '0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_flags_q <= tmo_flags_d;
    end
  end

  assign timeout_flags = tmo_flags_q;
`else
  assign adv           = (state_q == GRANT) && bus.done[idx_q];
  assign timeout_flags = '0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (consume) begin
          state_d = GRANT;
          idx_d   = '0;
        end
      end
      GRANT: begin
        if (adv) begin
          if (idx_q < LastIdx && bus.run) begin
            idx_d = idx_q + 1'b1;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so the grant moves on the done edge itself.
  always_comb begin
    grant_d = '0;
    if (state_d == GRANT) grant_d[idx_d] = 1'b1;
    busy_d       = (state_d == GRANT);
    step_start_d = consume;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      step_start_q <= 1'b0;
      step_cnt_q   <= '0;
      pend_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      step_start_q <= step_start_d;
      step_cnt_q   <= step_cnt_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.pix_en        = pix_en;
  assign bus.ms_tick       = ms_tick;
  assign bus.step_start    = step_start_q;
  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = overrun_q;
  assign bus.timeout_flags = timeout_flags;
endmodule
